// File: rtl/dcount_ud.sv
// Loadable up/down counter with programmable up-count limit, four terminal modes,
// registered terminal-count pulse and a run flag used by one-shot mode.
module dcount_ud #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:WIDTH-1] data,
    input  logic [0:WIDTH-1] limit,
    input  logic             load,
    input  logic             ena,
    input  logic             dir,
    input  logic [0:1]       mode,
    output logic [0:WIDTH-1] count,
    output logic             tc,
    output logic             run,
    output logic             zero
);

    typedef enum logic [1:0] {
        M_WRAP    = 2'd0,
        M_SAT     = 2'd1,
        M_RELOAD  = 2'd2,
        M_ONESHOT = 2'd3
    } mode_e;

    logic [WIDTH-1:0] data_v;
    logic [WIDTH-1:0] limit_v;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             run_q, run_d;
    logic             term;
    mode_e            mode_v;

    // Ports use ascending ranges with bit 0 as LSB; map index-for-index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign data_v[i]  = data[i];
        assign limit_v[i] = limit[i];
        assign count[i]   = count_q[i];
    end

    assign mode_v = mode_e'({mode[1], mode[0]});
    assign term   = dir ? (count_q == '0) : (count_q == limit_v);
    assign tc     = tc_q;
    assign run    = run_q;
    assign zero   = (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        run_d   = run_q;
        if (load) begin
            count_d = data_v;
            run_d   = 1'b1;
        end else if (ena && run_q) begin
            if (!term) begin
                count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end else begin
                tc_d = 1'b1;
                case (mode_v)
                    M_WRAP:    count_d = dir ? limit_v : '0;
                    M_SAT:     count_d = count_q;
                    M_RELOAD:  count_d = data_v;
                    M_ONESHOT: run_d   = 1'b0;
                    default:   count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            run_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_dcount_ud.sv
// Bench for dcount_ud: a 16-bit and a 4-bit instance share control inputs; an
// arithmetic model is compared every cycle, and directed steps pin literal values.
module tb_dcount_ud;

    logic        clk = 1'b0;
    logic        reset, load, ena, dir;
    logic [1:0]  mode_v;
    logic [31:0] data_v, limit_v;

    logic [0:15] d16, l16, c16;
    logic [0:3]  d4, l4, c4;
    logic [0:1]  mp;
    logic        tc16, run16, zero16, tc4, run4, zero4;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [0:15] t16(input logic [15:0] v);
        logic [0:15] r;
        for (int i = 0; i < 16; i++) r[i] = v[i];
        return r;
    endfunction
    function automatic logic [15:0] f16(input logic [0:15] p);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = p[i];
        return r;
    endfunction
    function automatic logic [0:3] t4(input logic [3:0] v);
        logic [0:3] r;
        for (int i = 0; i < 4; i++) r[i] = v[i];
        return r;
    endfunction
    function automatic logic [3:0] f4(input logic [0:3] p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = p[i];
        return r;
    endfunction

    assign d16 = t16(data_v[15:0]);
    assign l16 = t16(limit_v[15:0]);
    assign d4  = t4(data_v[3:0]);
    assign l4  = t4(limit_v[3:0]);
    assign mp  = {mode_v[0], mode_v[1]};

    dcount_ud #(.WIDTH(16), .RESET_VAL(16'h00A5)) u16 (
        .clk(clk), .reset(reset), .data(d16), .limit(l16), .load(load), .ena(ena),
        .dir(dir), .mode(mp), .count(c16), .tc(tc16), .run(run16), .zero(zero16)
    );
    dcount_ud #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .data(d4), .limit(l4), .load(load), .ena(ena),
        .dir(dir), .mode(mp), .count(c4), .tc(tc4), .run(run4), .zero(zero4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counter value as a plain integer modulo 2^w, per instance.
    int mw[2]  = '{16, 4};
    int mrv[2] = '{'hA5, 0};
    int mc[2];
    bit mt[2], mr[2];
    int m_mod, m_d, m_l;
    bit m_hit;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_mod = 1 << mw[k];
            m_d   = int'(data_v) % m_mod;
            m_l   = int'(limit_v) % m_mod;
            if (reset) begin
                mc[k] = mrv[k]; mt[k] = 1'b0; mr[k] = 1'b1;
            end else if (load) begin
                mc[k] = m_d; mt[k] = 1'b0; mr[k] = 1'b1;
            end else if (ena && mr[k]) begin
                m_hit = dir ? (mc[k] == 0) : (mc[k] == m_l);
                mt[k] = m_hit;
                if (!m_hit) mc[k] = dir ? (mc[k] + m_mod - 1) % m_mod : (mc[k] + 1) % m_mod;
                else if (mode_v == 2'd0) mc[k] = dir ? m_l : 0;
                else if (mode_v == 2'd2) mc[k] = m_d;
                else if (mode_v == 2'd3) mr[k] = 1'b0;
            end else begin
                mt[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model cnt16", f16(c16), mc[0]);
            chk("model tc16", tc16, mt[0]);
            chk("model run16", run16, mr[0]);
            chk("model zero16", zero16, mc[0] == 0);
            chk("model cnt4", f4(c4), mc[1]);
            chk("model tc4", tc4, mt[1]);
            chk("model run4", run4, mr[1]);
            chk("model zero4", zero4, mc[1] == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        ena = 1'b0; load = 1'b1; data_v = v;
        step();
        load = 1'b0;
    endtask

    int e2c[6] = '{2, 1, 0, 0, 0, 0};
    bit e2t[6] = '{0, 0, 0, 1, 1, 1};
    int e6c[13] = '{'hA, 'hB, 'hC, 'hD, 'hE, 'hF, 0, 1, 2, 3, 4, 5, 0};

    initial begin
        reset = 1'b1; load = 1'b0; ena = 1'b0; dir = 1'b0; mode_v = 2'd0;
        data_v = '0; limit_v = '0;
        step();
        chk_on = 1'b1;
        chk("reset cnt16", f16(c16), 32'hA5);
        chk("reset tc16", tc16, 1'b0);
        chk("reset run16", run16, 1'b1);
        chk("reset cnt4", f4(c4), 32'h0);
        chk("reset zero4", zero4, 1'b1);
        reset = 1'b0;

        // Up wrap at limit FFFF
        limit_v = 32'hFFFF;
        do_load(32'hFFFE);
        chk("load cnt16", f16(c16), 32'hFFFE);
        ena = 1'b1; dir = 1'b0; mode_v = 2'd0;
        step();
        chk("wrap1 cnt16", f16(c16), 32'hFFFF);
        chk("wrap1 tc16", tc16, 1'b0);
        step();
        chk("wrap2 cnt16", f16(c16), 32'h0);
        chk("wrap2 tc16", tc16, 1'b1);
        chk("wrap2 zero16", zero16, 1'b1);

        // Down saturate
        do_load(32'h3);
        ena = 1'b1; dir = 1'b1; mode_v = 2'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sat cnt16", f16(c16), e2c[i]);
            chk("sat tc16", tc16, e2t[i]);
        end

        // Down reload with data changed after load
        do_load(32'h2);
        data_v = 32'h10; ena = 1'b1; dir = 1'b1; mode_v = 2'd2;
        step(); chk("rel cnt a", f16(c16), 32'h1);  chk("rel tc a", tc16, 1'b0);
        step(); chk("rel cnt b", f16(c16), 32'h0);  chk("rel tc b", tc16, 1'b0);
        step(); chk("rel cnt c", f16(c16), 32'h10); chk("rel tc c", tc16, 1'b1);
        step(); chk("rel cnt d", f16(c16), 32'hF);  chk("rel tc d", tc16, 1'b0);

        // One-shot up to limit 7
        limit_v = 32'h7;
        do_load(32'h5);
        ena = 1'b1; dir = 1'b0; mode_v = 2'd3;
        step(); chk("os cnt a", f16(c16), 32'h6); chk("os run a", run16, 1'b1);
        step(); chk("os cnt b", f16(c16), 32'h7); chk("os tc b", tc16, 1'b0);
        step(); chk("os cnt c", f16(c16), 32'h7); chk("os tc c", tc16, 1'b1);
        chk("os run c", run16, 1'b0);
        step(); chk("os cnt d", f16(c16), 32'h7); chk("os tc d", tc16, 1'b0);
        chk("os run d", run16, 1'b0);
        load = 1'b1; data_v = 32'h0;
        step(); chk("os reload cnt", f16(c16), 32'h0); chk("os reload run", run16, 1'b1);
        load = 1'b0;
        step(); chk("os resume cnt", f16(c16), 32'h1);

        // load beats ena; reset beats load
        limit_v = 32'h1234; mode_v = 2'd0; dir = 1'b0;
        load = 1'b1; ena = 1'b1; data_v = 32'h1234;
        step(); chk("ld+ena cnt", f16(c16), 32'h1234); chk("ld+ena tc", tc16, 1'b0);
        load = 1'b0;
        step(); chk("term cnt", f16(c16), 32'h0); chk("term tc", tc16, 1'b1);
        reset = 1'b1; load = 1'b1;
        step(); chk("rst+ld cnt", f16(c16), 32'hA5); chk("rst+ld tc", tc16, 1'b0);
        chk("rst+ld run", run16, 1'b1);
        reset = 1'b0; load = 1'b0;
        limit_v = 32'hA6; mode_v = 2'd3;
        step(); step(); chk("os stop run", run16, 1'b0);
        reset = 1'b1;
        step(); chk("rst run", run16, 1'b1); chk("rst cnt", f16(c16), 32'hA5);
        reset = 1'b0;

        // 4-bit: overflow above limit passes through 0 silently
        limit_v = 32'h5;
        do_load(32'h9);
        ena = 1'b1; dir = 1'b0; mode_v = 2'd0;
        for (int i = 0; i < 13; i++) begin
            step();
            chk("w4 cnt", f4(c4), e6c[i]);
            chk("w4 tc", tc4, i == 12);
        end

        // limit 0, up: WRAP and SAT both stick at 0 with tc
        limit_v = 32'h0;
        do_load(32'h0);
        ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); chk("lim0 wrap cnt", f4(c4), 32'h0); chk("lim0 wrap tc", tc4, 1'b1);
        end
        mode_v = 2'd1;
        step(); chk("lim0 sat cnt", f4(c4), 32'h0); chk("lim0 sat tc", tc4, 1'b1);

        // Down wrap goes to limit
        limit_v = 32'h5; mode_v = 2'd0;
        do_load(32'h1);
        ena = 1'b1; dir = 1'b1;
        step(); chk("dwrap cnt a", f4(c4), 32'h0); chk("dwrap tc a", tc4, 1'b0);
        step(); chk("dwrap cnt b", f4(c4), 32'h5); chk("dwrap tc b", tc4, 1'b1);
        ena = 1'b0;
        step(); chk("hold cnt", f4(c4), 32'h5); chk("hold tc", tc4, 1'b0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
